// File: rtl/fan_btn_conditioner_pkg.sv
// rtl/fan_btn_conditioner_pkg.sv - shared fan button constants (package fan_pkg)
package fan_pkg;

    localparam int N_BTN_DEF = 5;

    // Channel indices the fan FSM uses to decode o_btn_pulse
    localparam int BTN_IDX_0 = 0;
    localparam int BTN_IDX_1 = 1;
    localparam int BTN_IDX_2 = 2;
    localparam int BTN_IDX_3 = 3;
    localparam int BTN_IDX_4 = 4;

    // 1 ms debounce, 500 ms first repeat, 100 ms repeat period at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 100000;
    localparam int REPEAT_DELAY_DEF    = 50000000;
    localparam int REPEAT_PERIOD_DEF   = 10000000;

    // Width of a counter that must hold values 0..max_count
    function automatic int count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/fan_btn_conditioner_if.sv
// rtl/fan_btn_conditioner_if.sv - button bundle between board pins, conditioner and fan FSM
interface fan_btn_conditioner_if
    import fan_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
) ();

    logic [N_BTN-1:0] i_button;
    logic [N_BTN-1:0] o_btn_pulse;
    logic [N_BTN-1:0] o_btn_level;

    modport master (
        output i_button,
        input  o_btn_pulse,
        input  o_btn_level
    );

    modport slave (
        input  i_button,
        output o_btn_pulse,
        output o_btn_level
    );

endinterface

// File: rtl/fan_btn_conditioner_debounce_ch.sv
// rtl/fan_btn_conditioner_debounce_ch.sv - one button channel: sync, debounce, press pulse (auto-repeat with FAN_BTN_REPEAT_EN)
module fan_btn_debounce_ch
    import fan_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_btn_pulse,
    output logic o_btn_level
);

    localparam int              CNT_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard on the timing parameters
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("fan_btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             expire;
    logic             rise;
    logic             repeat_fire;

    // sync has disagreed with level for DEBOUNCE_CYCLES consecutive edges
    assign expire = (sync != level) && (cnt == CNT_LAST);
    assign rise   = expire && sync;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= i_button;
            sync      <= sync_meta;
        end
    end

    // Debounce: any agreement restarts the count; terminal count accepts the new level
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync == level) begin
            cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

`ifdef FAN_BTN_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = count_width(REP_MAX);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;
    logic             fall;

    assign fall        = expire && !sync;
    // First repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD apart
    assign repeat_fire = level && !fall &&
                         (rep_armed ? (rep_cnt == REP_W'(REPEAT_PERIOD - 1))
                                    : (rep_cnt == REP_W'(REPEAT_DELAY - 1)));

    // Repeat timer runs only while the debounced level is held
    always_ff @(posedge i_clk) begin
        if (i_reset || !level || fall) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (repeat_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt + REP_W'(1);
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // Registered strobe, coincident with the 0->1 step of level
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_btn_pulse <= 1'b0;
        end else begin
            o_btn_pulse <= rise || repeat_fire;
        end
    end

    assign o_btn_level = level;

endmodule

// File: rtl/fan_btn_conditioner.sv
// rtl/fan_btn_conditioner.sv - N_BTN independent debounced button channels; FAN_BTN_REPEAT_EN adds auto-repeat
module fan_btn_conditioner
    import fan_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    fan_btn_conditioner_if.slave  btn
);

    logic [N_BTN-1:0] pulse_vec;
    logic [N_BTN-1:0] level_vec;

    // One fully independent conditioner per button
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        fan_btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_button    (btn.i_button[g]),
            .o_btn_pulse (pulse_vec[g]),
            .o_btn_level (level_vec[g])
        );
    end

    assign btn.o_btn_pulse = pulse_vec;
    assign btn.o_btn_level = level_vec;

endmodule

// File: tb/tb_fan_btn_conditioner.sv
// tb/tb_fan_btn_conditioner.sv - scoreboard bench for fan_btn_conditioner (FAN_BTN_REPEAT_EN optional)
module tb_fan_btn_conditioner;
    import fan_pkg::*;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    typedef struct packed {
        logic [NB-1:0] level;
        logic [NB-1:0] pulse;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #1 clk = ~clk;

    fan_btn_conditioner_if #(.N_BTN(NB)) bif ();

    fan_btn_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .btn     (bif)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t          exp_q[$];
    logic [NB-1:0] samp_hist[$];
    logic [NB-1:0] sync_hist[$];
    logic [NB-1:0] m_level;
    int            m_age[NB];
    logic [NB-1:0] m_syn;
    logic [NB-1:0] m_pls;
    bit            m_diff;

    int            pcnt[NB];
    bit            seen_11000;

    // Reference model: the button as seen two edges late must disagree with the
    // accepted level for DB consecutive edges before the level flips.
    always @(posedge clk) begin
        m_pls = '0;
        if (rst) begin
            m_level = '0;
            samp_hist.delete();
            samp_hist.push_back('0);
            samp_hist.push_back('0);
            sync_hist.delete();
            for (int i = 0; i < NB; i++) m_age[i] = 0;
        end else begin
            m_syn = samp_hist.pop_front();
            samp_hist.push_back(bif.i_button);
            sync_hist.push_back(m_syn);
            if (sync_hist.size() > DB) void'(sync_hist.pop_front());
            for (int i = 0; i < NB; i++) begin
                m_diff = (sync_hist.size() == DB);
                foreach (sync_hist[j]) if (sync_hist[j][i] == m_level[i]) m_diff = 0;
                if (m_diff) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        m_pls[i] = 1'b1;
                        m_age[i] = 0;
                    end
                end else if (m_level[i]) begin
                    m_age[i]++;
`ifdef FAN_BTN_REPEAT_EN
                    if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
                        m_pls[i] = 1'b1;
`endif
                end
            end
        end
        exp_q.push_back('{level: m_level, pulse: m_pls});
    end

    // Monitor: pops one expectation per cycle and compares away from the edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bif.o_btn_level !== e.level || bif.o_btn_pulse !== e.pulse) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d got level=%b pulse=%b expected level=%b pulse=%b",
                         cyc, bif.o_btn_level, bif.o_btn_pulse, e.level, e.pulse);
            end
            for (int i = 0; i < NB; i++) if (bif.o_btn_pulse[i] === 1'b1) pcnt[i]++;
            if (bif.o_btn_pulse === 5'b11000) seen_11000 = 1'b1;
        end
    end

    task automatic set_in(input logic r, input logic [NB-1:0] b);
        @(negedge clk);
        rst          = r;
        bif.i_button = b;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counter snapshots are taken at the rising edge, clear of monitor updates
    task automatic snap();
        @(posedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Cycles from the input change until o_btn_level[idx] reaches target (bounded)
    task automatic measure(input int idx, input logic target, input int want, input string name);
        int  n    = 0;
        bit  seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bif.o_btn_level[idx] === target) seen = 1;
        end
        checks++;
        if (!seen || n != want) begin
            errors++;
            $display("FAIL %s latency got %0d (reached=%0b) expected %0d", name, n, seen, want);
        end
    endtask

    initial begin
        int base;
        int base_b;
        logic [NB-1:0] b;
        logic [NB-1:0] bounce[5];

        for (int i = 0; i < NB; i++) pcnt[i] = 0;
        seen_11000   = 1'b0;
        rst          = 1'b1;
        bif.i_button = 5'b00001;

        // 1: button held through reset, one pulse after release
        hold(10);
        snap();
        check_int("reset_no_pulse", pcnt[0], 0);
        set_in(1'b0, 5'b00001);
        measure(0, 1'b1, 6, "reset_release_rise");
        hold(10);
        snap();
        check_int("reset_release_pulses", pcnt[0], 1);

        // 2: clean press and release of bit1
        set_in(1'b0, '0);
        hold(10);
        snap();
        base = pcnt[1];
        set_in(1'b0, 5'b00010);
        measure(1, 1'b1, 6, "press_rise");
        hold(14);
        set_in(1'b0, '0);
        measure(1, 1'b0, 6, "release_fall");
        hold(4);
        snap();
        check_int("press_pulses", pcnt[1] - base, 1);

        // 3: bounce on bit2 then settle high
        base = pcnt[2];
        bounce = '{5'b00100, 5'b00000, 5'b00100, 5'b00100, 5'b00000};
        for (int k = 0; k < 5; k++) set_in(1'b0, bounce[k]);
        snap();
        check_int("bounce_no_pulse", pcnt[2] - base, 0);
        set_in(1'b0, 5'b00100);
        measure(2, 1'b1, 6, "bounce_rise");
        hold(10);
        snap();
        check_int("bounce_pulses", pcnt[2] - base, 1);

        // 4: simultaneous press on bits 3 and 4
        set_in(1'b0, '0);
        hold(10);
        snap();
        base   = pcnt[3];
        base_b = pcnt[4];
        seen_11000 = 1'b0;
        set_in(1'b0, 5'b11000);
        hold(12);
        snap();
        check_int("simul_same_cycle", int'(seen_11000), 1);
        check_int("simul_bit3", pcnt[3] - base, 1);
        check_int("simul_bit4", pcnt[4] - base_b, 1);

        // 5: reset mid-count discards progress
        set_in(1'b0, '0);
        hold(10);
        snap();
        base = pcnt[3];
        set_in(1'b0, 5'b01000);
        hold(3);
        set_in(1'b1, 5'b01000);
        snap();
        check_int("midreset_no_pulse", pcnt[3] - base, 0);
        set_in(1'b0, 5'b01000);
        measure(3, 1'b1, 6, "midreset_rise");
        snap();
        check_int("midreset_pulses", pcnt[3] - base, 1);

`ifdef FAN_BTN_REPEAT_EN
        // 6: auto-repeat on bit4
        set_in(1'b0, '0);
        hold(10);
        snap();
        base = pcnt[4];
        set_in(1'b0, 5'b10000);
        hold(40);
        snap();
        check_int("repeat_pulses", pcnt[4] - base, 6);
        set_in(1'b0, '0);
        hold(20);
`endif

        // Randomised stretches of button patterns with occasional reset
        set_in(1'b0, '0);
        hold(10);
        b = '0;
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 2) == 0) b = NB'($urandom);
            else b[$urandom_range(0, NB - 1)] ^= 1'b1;
            set_in(($urandom_range(0, 40) == 0), b);
            hold($urandom_range(0, 7));
        end
        set_in(1'b0, '0);
        hold(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
